unidad_fetch: RTL and testbench
===============================

Name: unidad_fetch

Overview:
- Instruction-fetch stage of the monocycle-derived datapath.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Presents the fetched 32-bit instruction to decode; decode's instr[15:0] feeds the sign extender.
- Consumes the sign-extended 32-bit immediate back as the branch offset, together with jump and jr redirects, to form the next PC.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, always equal to pc_out
imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  latched instruction for decode
instr_valid  output  1  instr holds a valid instruction
instr_ack  input  1  decode has consumed instr; redirect inputs are sampled in this cycle
pc_out  output  32  address of the instruction in instr / being fetched
pc_plus4  output  32  pc_out + 4, modulo 2^32
branch_take  input  1  take the conditional branch
branch_offset  input  32  sign-extended immediate from the sign extender
jump_take  input  1  J/JAL redirect
jump_index  input  26  instr_index field
jr_take  input  1  register-indirect redirect
jr_target  input  32  register value for jr
misaligned  output  1  sticky fault: jr_target not word-aligned

Behaviour:
- Reset (asynchronous, on rst_n low, regardless of state):
  - state=IDLE, pc_out=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, misaligned=0.
  - Any in-flight handshake is abandoned.
- States:
  - IDLE: first clock after rst_n rises → FETCH.
  - FETCH: imem_req=1, imem_addr=pc_out. While imem_ready=0, stay in FETCH with address stable. When imem_ready=1, instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - HOLD: imem_req=0, instr and instr_valid stable until instr_ack=1. On ack: instr_valid<=0, pc_out<=next_pc, go to FETCH, unless a misaligned jr is taken (see HALT).
  - HALT: imem_req=0, instr_valid=0, misaligned=1, PC frozen. Left only by reset.
- next_pc, priority jr > jump > branch > sequential:
  - jr: jr_target. If jr_target[1:0]!=0 → HALT and misaligned<=1; PC is not updated.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch: pc_plus4 + (branch_offset<<2), 32-bit wrap, overflow ignored.
  - sequential: pc_plus4.
- Redirect inputs are ignored outside an acked HOLD cycle. instr_ack outside HOLD is ignored.
- Timing:
  - Fetch latency: 1 cycle from FETCH with imem_ready=1 to instr_valid=1.
  - Best throughput: 1 instruction per 2 cycles (ack in the first HOLD cycle).
- Wrap-around: pc_out=32'hFFFF_FFFC, sequential → 32'h0000_0000. Branch and jump arithmetic wraps the same way.
- pc_plus4 is combinational from pc_out.
- pc_out[1:0] is always 2'b00.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, FETCH, HOLD, HALT;
  - WORD_BYTES=4;
  - RESET_PC default;
  - redirect select constants.
- Sub-module next_pc_sel (combinational): priority mux and target adders, inputs pc_plus4/redirects, output next_pc plus a misaligned-request flag.
- unidad_fetch keeps the FSM, the PC register and the instr register.

Test Plan:
- Reset release, imem_ready=1, ack each HOLD → imem_addr 0x0, 0x4, 0x8 on alternate cycles; instr_valid 1 cycle after each ready.
- imem_ready low for 3 cycles in FETCH → imem_req high with imem_addr stable for 4 cycles; instr_valid rises only after ready.
- pc=0x100, branch_take, branch_offset=32'hFFFF_FFFE on ack → next imem_addr 0xFC. Repeat with offset 0x0000_0010 → 0x144.
- pc=0x1000_0040, jump_index=26'h000_0010 together with branch_take → target 0x1000_0040 (jump wins over branch). jr_take with jr_target=0x0000_2000 plus jump → 0x2000.
- jr_target=0x0000_2002 on ack → misaligned=1, imem_req stays 0, PC frozen until reset; rst_n low clears misaligned.
- PC at 0xFFFF_FFFC sequential → 0x0. rst_n asserted mid-FETCH with imem_ready=0 → imem_req drops immediately, pc_out=RESET_PC.

Source files
------------

// File: rtl/unidad_fetch_pkg.sv
// rtl/unidad_fetch_pkg.sv - shared constants for the instruction-fetch stage
package unidad_fetch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] SEL_SEQ    = 2'd0;
   localparam logic [1:0] SEL_BRANCH = 2'd1;
   localparam logic [1:0] SEL_JUMP   = 2'd2;
   localparam logic [1:0] SEL_JR     = 2'd3;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return addr_lsb == 2'b00;
   endfunction

endpackage

// File: rtl/unidad_fetch_next_pc_sel.sv
// rtl/unidad_fetch_next_pc_sel.sv - next-PC priority mux (jr > jump > branch > sequential)
module unidad_fetch_next_pc_sel
   import unidad_fetch_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic        branch_take,
   input  logic [31:0] branch_offset,
   input  logic        jump_take,
   input  logic [25:0] jump_index,
   input  logic        jr_take,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misaligned_req
);

   logic [1:0]  sel;
   logic [31:0] branch_target;
   logic [31:0] jump_target;

   assign branch_target = pc_plus4 + (branch_offset << 2);
   assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

   always_comb begin
      sel = SEL_SEQ;
      if (jr_take) begin
         sel = SEL_JR;
      end else if (jump_take) begin
         sel = SEL_JUMP;
      end else if (branch_take) begin
         sel = SEL_BRANCH;
      end
   end

   always_comb begin
      next_pc        = pc_plus4;
      misaligned_req = 1'b0;
      case (sel)
         SEL_JR: begin
            next_pc        = jr_target;
            misaligned_req = !is_word_aligned(jr_target[1:0]);
         end
         SEL_JUMP:   next_pc = jump_target;
         SEL_BRANCH: next_pc = branch_target;
         default:    next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/unidad_fetch.sv
// rtl/unidad_fetch.sv - fetch FSM, PC register and instruction latch
module unidad_fetch
   import unidad_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ack,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        branch_take,
   input  logic [31:0] branch_offset,
   input  logic        jump_take,
   input  logic [25:0] jump_index,
   input  logic        jr_take,
   input  logic [31:0] jr_target,
   output logic        misaligned
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;
   logic [31:0] next_pc;
   logic        mis_req;

   assign pc_plus4 = pc_q + 32'(WORD_BYTES);

   unidad_fetch_next_pc_sel u_next_pc_sel (
      .pc_plus4       (pc_plus4),
      .branch_take    (branch_take),
      .branch_offset  (branch_offset),
      .jump_take      (jump_take),
      .jump_index     (jump_index),
      .jr_take        (jr_take),
      .jr_target      (jr_target),
      .next_pc        (next_pc),
      .misaligned_req (mis_req)
   );

   // Redirects only matter on an acked HOLD cycle; everywhere else they are ignored.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mis_d   = mis_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (instr_ack) begin
               valid_d = 1'b0;
               if (mis_req) begin
                  mis_d   = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = ST_FETCH;
               end
            end
         end
         default: valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= {RESET_PC[31:2], 2'b00};
         instr_q <= '0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign pc_out      = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_unidad_fetch.sv
// tb/tb_unidad_fetch.sv - scoreboard bench for unidad_fetch
module tb_unidad_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ack;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        branch_take;
   logic [31:0] branch_offset;
   logic        jump_take;
   logic [25:0] jump_index;
   logic        jr_take;
   logic [31:0] jr_target;
   logic        misaligned;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];

   always #5 clk = ~clk;

   unidad_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ack     (instr_ack),
      .pc_out        (pc_out),
      .pc_plus4      (pc_plus4),
      .branch_take   (branch_take),
      .branch_offset (branch_offset),
      .jump_take     (jump_take),
      .jump_index    (jump_index),
      .jr_take       (jr_take),
      .jr_target     (jr_target),
      .misaligned    (misaligned)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   task automatic wait_req(input int exp_wait);
      int n = 0;
      while (imem_req !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check_eq("req_seen", 32'(imem_req), 32'd1);
      check_eq("req_latency", 32'(n), 32'(exp_wait));
   endtask

   function automatic logic [31:0] pop_addr();
      checks++;
      if (exp_addr_q.size() == 0) begin
         errors++;
         $display("FAIL sb_empty got=0 exp=nonempty t=%0t", $time);
         return 32'hDEAD_DEAD;
      end
      return exp_addr_q.pop_front();
   endfunction

   task automatic fetch(input int stall);
      logic [31:0] a;
      a = pop_addr();
      check_eq("fetch_addr", imem_addr, a);
      check_eq("pc_out", pc_out, a);
      check_eq("pc_plus4", pc_plus4, a + 32'd4);
      for (int i = 0; i < stall; i++) begin
         imem_ready = 1'b0;
         @(negedge clk);
         check_eq("stall_req", 32'(imem_req), 32'd1);
         check_eq("stall_addr", imem_addr, a);
         check_eq("stall_valid", 32'(instr_valid), 32'd0);
      end
      imem_ready = 1'b1;
      imem_rdata = mem_word(a);
      exp_instr_q.push_back(mem_word(a));
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = '0;
      check_eq("valid", 32'(instr_valid), 32'd1);
      check_eq("req_drop", 32'(imem_req), 32'd0);
      check_eq("instr", instr, exp_instr_q.pop_front());
   endtask

   task automatic ack(input logic br, input logic [31:0] off, input logic jp,
                      input logic [25:0] idx, input logic jr, input logic [31:0] tgt,
                      input logic push, input logic [31:0] exp_next);
      if (push) exp_addr_q.push_back(exp_next);
      instr_ack     = 1'b1;
      branch_take   = br;
      branch_offset = off;
      jump_take     = jp;
      jump_index    = idx;
      jr_take       = jr;
      jr_target     = tgt;
      @(negedge clk);
      instr_ack     = 1'b0;
      branch_take   = 1'b0;
      jump_take     = 1'b0;
      jr_take       = 1'b0;
   endtask

   task automatic redirect_fetch(input logic br, input logic [31:0] off, input logic jp,
                                 input logic [25:0] idx, input logic jr, input logic [31:0] tgt,
                                 input logic [31:0] exp_next);
      ack(br, off, jp, idx, jr, tgt, 1'b1, exp_next);
      wait_req(0);
      fetch(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      rst_n = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = '0;
      instr_ack = 1'b0;
      branch_take = 1'b0;
      branch_offset = '0;
      jump_take = 1'b0;
      jump_index = '0;
      jr_take = 1'b0;
      jr_target = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_req", 32'(imem_req), 32'd0);
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_pc", pc_out, 32'h0);
      check_eq("rst_instr", instr, 32'h0);
      check_eq("rst_mis", 32'(misaligned), 32'd0);

      rst_n = 1'b1;
      exp_addr_q.push_back(32'h0);
      wait_req(1);
      fetch(0);
      redirect_fetch(0, '0, 0, '0, 0, '0, 32'h4);
      ack(0, '0, 0, '0, 0, '0, 1'b1, 32'h8);
      wait_req(0);
      fetch(3);

      // HOLD without ack: redirects must be ignored, instr stable
      branch_take = 1'b1;
      branch_offset = 32'h100;
      jump_take = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_eq("hold_valid", 32'(instr_valid), 32'd1);
         check_eq("hold_req", 32'(imem_req), 32'd0);
         check_eq("hold_pc", pc_out, 32'h8);
         check_eq("hold_instr", instr, mem_word(32'h8));
      end
      branch_take = 1'b0;
      jump_take = 1'b0;

      redirect_fetch(0, '0, 1, 26'h40, 0, '0, 32'h100);
      redirect_fetch(1, 32'hFFFF_FFFE, 0, '0, 0, '0, 32'hFC);
      redirect_fetch(0, '0, 1, 26'h40, 0, '0, 32'h100);
      redirect_fetch(1, 32'h0000_0010, 0, '0, 0, '0, 32'h144);
      redirect_fetch(0, '0, 0, '0, 1, 32'h1000_0040, 32'h1000_0040);
      redirect_fetch(1, 32'h8, 1, 26'h10, 0, '0, 32'h1000_0040);
      redirect_fetch(0, '0, 1, 26'h5, 1, 32'h0000_2000, 32'h2000);

      ack(0, '0, 0, '0, 1, 32'h0000_2002, 1'b0, '0);
      imem_ready = 1'b1;
      repeat (3) begin
         check_eq("halt_mis", 32'(misaligned), 32'd1);
         check_eq("halt_req", 32'(imem_req), 32'd0);
         check_eq("halt_valid", 32'(instr_valid), 32'd0);
         check_eq("halt_pc", pc_out, 32'h2000);
         instr_ack = 1'b1;
         @(negedge clk);
      end
      instr_ack = 1'b0;
      imem_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_eq("rst_clears_mis", 32'(misaligned), 32'd0);
      check_eq("rst_pc2", pc_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_addr_q.push_back(32'h0);
      wait_req(1);
      fetch(0);

      redirect_fetch(0, '0, 0, '0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      redirect_fetch(0, '0, 0, '0, 0, '0, 32'h0);

      ack(0, '0, 0, '0, 1, 32'h0000_2000, 1'b1, 32'h2000);
      wait_req(0);
      a = pop_addr();
      check_eq("midfetch_addr", imem_addr, a);
      @(negedge clk);
      check_eq("midfetch_req", 32'(imem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_eq("async_rst_req", 32'(imem_req), 32'd0);
      check_eq("async_rst_pc", pc_out, 32'h0);
      check_eq("async_rst_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("sb_drained", 32'(exp_addr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
